// File: rtl/timer_arbiter_pkg.sv
// Shared types and constants for the two-requester timer arbiter.
package timer_arbiter_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned NUM_REQ   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/down_counter_load.sv
// Loadable down-counter that saturates at zero; clear beats load beats enable.
module down_counter_load
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         zero_c
);

  // Counter register: never decrements below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting a shared down-counting timer to one of two requesters.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [CNT_W-1:0]   load_val0,
  input  logic [CNT_W-1:0]   load_val1,
  input  logic               abort,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic [CNT_W-1:0]   count,
  output logic [NUM_REQ-1:0] done
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               ptr_q, ptr_d;
  logic               winner;
  logic [CNT_W-1:0]   load_mux;
  logic               cnt_load, cnt_en, cnt_clr, cnt_zero;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               busy_d;

  // Winner selection: pointer breaks ties, otherwise the sole requester wins.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = ptr_q;
    end
    load_mux = winner ? load_val1 : load_val0;
  end

  down_counter_load #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (load_mux),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .count    (count),
    .zero_c   (cnt_zero)
  );

  // Next-state, owner, pointer and counter control.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d  = RUN;
          owner_d  = winner;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (abort || !req[owner_q]) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          if (abort) begin
            ptr_d = ~owner_q;
          end
        end else if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else begin
          state_d = DONE;
          ptr_d   = ~owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d  = (state_d != IDLE);
    grant_d = busy_d ? to_onehot(owner_d) : '0;
    done_d  = (state_d == DONE) ? to_onehot(owner_q) : '0;
  end

  // State, bookkeeping and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant   <= grant_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter CNT_W, default 4, SHALL set the width of the shared down-counter and of the load values.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-requester request for the shared timer; bit i belongs to requester i.
REQ-005 load_val0  input  CNT_W  start count for requester 0, sampled only at grant.
REQ-006 load_val1  input  CNT_W  start count for requester 1, sampled only at grant.
REQ-007 abort  input  1  synchronous cancel of the current timing run.
REQ-008 grant  output  2  one-hot ownership indication; all zero when idle.
REQ-009 busy  output  1  high whenever the timer is owned.
REQ-010 count  output  CNT_W  current down-counter value.
REQ-011 done  output  2  one-cycle completion pulse to the owner.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE: if any req bit is high at a clock edge, the block SHALL latch the winner as owner, set count to that owner's load value and enter RUN.
REQ-014 Arbitration SHALL be round-robin over 2 requesters: with both requesting, the requester not served most recently wins.
REQ-015 The priority pointer SHALL favour requester 0 after reset, and SHALL move to the other requester after each DONE or abort of a run.
REQ-016 grant[owner] SHALL be high in RUN and DONE only; busy SHALL equal (state != IDLE).
REQ-017 RUN with count != 0: count SHALL decrement by 1 each cycle.
REQ-018 RUN with count == 0: the FSM SHALL enter DONE, and count SHALL hold 0.
REQ-019 Latency from the first grant cycle to the done cycle SHALL be load_val+1 cycles. load_val = 0 SHALL give RUN for one cycle, then DONE.
REQ-020 count SHALL never wrap below 0 and SHALL never exceed the loaded value.
REQ-021 DONE: done[owner] SHALL be high for exactly that cycle, and the FSM SHALL then return to IDLE.
REQ-022 DONE is the minimum one-cycle gap between runs; req in DONE SHALL NOT be granted until IDLE.
REQ-023 If abort is high, or the owner's req drops, while in RUN, the FSM SHALL go to IDLE at that edge with count <= 0 and no done pulse.
REQ-024 abort in IDLE or DONE SHALL be ignored.
REQ-025 req of the non-owner SHALL have no effect while busy.
REQ-026 load_val inputs SHALL be ignored except at the grant edge.

Reset
REQ-027 reset high SHALL immediately force, regardless of clk: state IDLE, grant 0, busy 0, done 0, count 0, owner 0, pointer favouring requester 0.
REQ-028 Reset mid-run SHALL discard the run with no done pulse.
REQ-029 The first grant after reset deassertion SHALL occur at the first rising edge with req high.

Structure
REQ-030 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE), CNT_W default and requester count (2).
REQ-031 The counter SHALL be a sub-module, down_counter_load: async reset, synchronous load, enable and clear, with zero flag output.
REQ-032 timer_arbiter SHALL contain only the FSM, the round-robin pointer, the owner register and the load-value mux.

Verification
REQ-033 Scenario: reset, req=01, load_val0=3 -> grant=01 for 5 cycles; count 3,2,1,0,0; done=01 in the 5th cycle; busy falls after.
REQ-034 Scenario: req=11 held after reset, load values 2 and 1 -> requester 0 served first (done after 3 cycles), one idle gap, then requester 1 (done after 2 cycles), then requester 0 again.
REQ-035 Scenario: load_val1=0, req=10 -> one RUN cycle with count 0, then done=10.
REQ-036 Scenario: load_val0=9, abort high at the 4th RUN cycle -> IDLE next cycle, count 0, no done; next req=11 grants requester 1.
REQ-037 Scenario: reset asserted mid-RUN between clock edges -> all outputs 0 immediately; no done after reset release.
REQ-038 Scenario: owner drops req during RUN -> IDLE at that edge, no done; non-owner req during RUN ignored until IDLE.
